// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780 byte writer: FSM state encoding,
// FIFO entry layout, the escape byte, the power-up command ROM, the
// clear/home command codes and microsecond-to-cycle conversion helpers.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT,
      ST_IDLE,
      ST_SETUP,
      ST_E_HIGH,
      ST_HOLD,
      ST_WAIT
   } lcd_state_t;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_entry_t;

   localparam logic [7:0] ESCAPE_BYTE  = 8'hFE;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   localparam int unsigned INIT_LEN  = 5;
   localparam logic [2:0]  INIT_LAST = 3'(INIT_LEN - 1);

   // Power-up command ROM: 8-bit/2-line/5x8 twice, display on, clear, entry mode.
   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      logic [7:0] cmd;
      case (idx)
         3'd0:    cmd = 8'h38;
         3'd1:    cmd = 8'h38;
         3'd2:    cmd = 8'h0C;
         3'd3:    cmd = CMD_CLEAR;
         3'd4:    cmd = 8'h06;
         default: cmd = 8'h00;
      endcase
      return cmd;
   endfunction

   // Clear and home commands need the long execution wait.
   function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
   endfunction

   // Microseconds to clock cycles, never less than one cycle.
   function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_hz);
      logic [63:0] cyc;
      cyc = (64'(us) * 64'(clk_hz)) / 64'd1_000_000;
      if (cyc == 64'd0) begin
         cyc = 64'd1;
      end
      return 32'(cyc);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// lcd_byte_writer_if
// Bundles the SPI frame inputs and the LCD/status outputs of the byte writer.
//   slave  : the writer (consumes i_ss/i_data, drives LCD pins and status)
//   master : the MCU/LCD side (drives i_ss/i_data, observes everything else)
interface lcd_byte_writer_if;
   logic       i_ss;
   logic [7:0] i_data;
   logic       o_lcd_rs;
   logic       o_lcd_rw;
   logic       o_lcd_e;
   logic [7:0] o_lcd_data;
   logic       o_ready;
   logic       o_busy;
   logic       o_overflow;

   modport slave (
      input  i_ss, i_data,
      output o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_data, o_ready, o_busy, o_overflow
   );

   modport master (
      output i_ss, i_data,
      input  o_lcd_rs, o_lcd_rw, o_lcd_e, o_lcd_data, o_ready, o_busy, o_overflow
   );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo
// Synchronous first-word-fall-through FIFO of {rs, byte} entries.
//   i_clk, i_reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_push_data : write request and entry
//   i_pop/o_pop_data   : read request and head entry (valid when !o_empty)
//   o_full/o_empty     : occupancy flags
//   o_drop             : one-cycle pulse when a push is refused because full
module lcd_cmd_fifo
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_push,
   input  lcd_entry_t i_push_data,
   input  logic       i_pop,
   output lcd_entry_t o_pop_data,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   lcd_entry_t  mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees a slot in the same cycle, so a push is still taken when full.
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);
   assign o_drop  = i_push && o_full && !do_pop;

   assign o_pop_data = mem[rd_ptr[AW-1:0]];

   // Pointers carry one extra wrap bit to tell full from empty.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset; the pointers decide what is valid.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= i_push_data;
      end
   end

endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer
// Takes the byte latched by the SPI shift register at each slave-select rising
// edge, queues it and writes it to an HD44780 LCD in 8-bit write-only mode,
// after running the power-up init sequence and honouring execution delays.
// A 0xFE prefix turns the following byte into a command (rs=0).
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus.i_ss/i_data  : raw slave-select and latched SPI byte
//   bus.o_lcd_*      : LCD RS/RW/E/DB[7:0]
//   bus.o_ready      : init sequence finished
//   bus.o_busy       : anything pending or in progress
//   bus.o_overflow   : sticky, a byte was dropped on a full FIFO
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 100_000_000,
   parameter int unsigned POWERUP_US    = 40000,
   parameter int unsigned EXEC_US       = 50,
   parameter int unsigned CLEAR_US      = 2000,
   parameter int unsigned SETUP_CYCLES  = 4,
   parameter int unsigned E_HIGH_CYCLES = 50,
   parameter int unsigned HOLD_CYCLES   = 2,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   lcd_byte_writer_if.slave   bus
);

   localparam int unsigned POWERUP_CYC = us_to_cyc(POWERUP_US, CLK_FREQ_HZ);
   localparam int unsigned EXEC_CYC    = us_to_cyc(EXEC_US, CLK_FREQ_HZ);
   localparam int unsigned CLEAR_CYC   = us_to_cyc(CLEAR_US, CLK_FREQ_HZ);
   localparam int unsigned MAX_CYC     = max_u(max_u(POWERUP_CYC, CLEAR_CYC),
                                               max_u(EXEC_CYC, max_u(E_HIGH_CYCLES,
                                                     max_u(SETUP_CYCLES, HOLD_CYCLES))));
   localparam int CNT_W = $clog2(MAX_CYC + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t POWERUP_M1 = cnt_t'(POWERUP_CYC - 1);
   localparam cnt_t EXEC_M1    = cnt_t'(EXEC_CYC - 1);
   localparam cnt_t CLEAR_M1   = cnt_t'(CLEAR_CYC - 1);
   localparam cnt_t SETUP_M1   = cnt_t'(SETUP_CYCLES - 1);
   localparam cnt_t E_HIGH_M1  = cnt_t'(E_HIGH_CYCLES - 1);
   localparam cnt_t HOLD_M1    = cnt_t'(HOLD_CYCLES - 1);

   logic       ss_meta, ss_sync, ss_prev;
   logic       frame_end;
   logic       esc_q, esc_d;
   logic       push;
   lcd_entry_t push_data;
   logic       pop;
   lcd_entry_t head;
   logic       fifo_full, fifo_empty, fifo_drop;

   lcd_state_t state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic       ready_q, ready_d;
   logic       rs_q, rs_d;
   logic [7:0] data_q, data_d;
   logic       e_q;
   logic       overflow_q;

   assign frame_end = ss_sync && !ss_prev;

   // Slave-select synchroniser plus edge history. These reset high because
   // slave-select idles high, so leaving reset never looks like a frame end.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ss_meta <= 1'b1;
         ss_sync <= 1'b1;
         ss_prev <= 1'b1;
         esc_q   <= 1'b0;
      end else begin
         ss_meta <= bus.i_ss;
         ss_sync <= ss_meta;
         ss_prev <= ss_sync;
         esc_q   <= esc_d;
      end
   end

   // Escape decoding: a lone 0xFE arms the flag, the next byte goes out as a
   // command. The flag is consumed even when the FIFO refuses the push.
   always_comb begin
      push      = 1'b0;
      push_data = '{rs: !esc_q, data: bus.i_data};
      esc_d     = esc_q;
      if (frame_end) begin
         if ((bus.i_data == ESCAPE_BYTE) && !esc_q) begin
            esc_d = 1'b1;
         end else begin
            push  = 1'b1;
            esc_d = 1'b0;
         end
      end
   end

   lcd_cmd_fifo #(
      .DEPTH       (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_push      (push),
      .i_push_data (push_data),
      .i_pop       (pop),
      .o_pop_data  (head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_drop      (fifo_drop)
   );

   // Sequencer registers. E is registered from the next state so the strobe
   // is glitch-free and drops at once on reset.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_POWERUP;
         cnt_q      <= POWERUP_M1;
         idx_q      <= 3'd0;
         ready_q    <= 1'b0;
         rs_q       <= 1'b0;
         data_q     <= 8'h00;
         e_q        <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         ready_q    <= ready_d;
         rs_q       <= rs_d;
         data_q     <= data_d;
         e_q        <= (state_d == ST_E_HIGH);
         overflow_q <= overflow_q || fifo_drop;
      end
   end

   // Next-state logic. Every timed state is entered with its length minus one
   // loaded into the shared counter and leaves when it reaches zero. INIT and
   // IDLE each spend one cycle latching the next command/data onto the pins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      ready_d = ready_q;
      rs_d    = rs_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         ST_POWERUP: begin
            if (cnt_q == '0) begin
               state_d = ST_INIT;
               idx_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_INIT: begin
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q);
            cnt_d   = SETUP_M1;
            state_d = ST_SETUP;
         end
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               rs_d    = head.rs;
               data_d  = head.data;
               cnt_d   = SETUP_M1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = E_HIGH_M1;
               state_d = ST_E_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_E_HIGH: begin
            if (cnt_q == '0) begin
               cnt_d   = HOLD_M1;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               cnt_d   = is_clear_cmd(rs_q, data_q) ? CLEAR_M1 : EXEC_M1;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (ready_q) begin
               state_d = ST_IDLE;
            end else if (idx_q == INIT_LAST) begin
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = ST_INIT;
            end
         end
         default: begin
            cnt_d   = POWERUP_M1;
            state_d = ST_POWERUP;
         end
      endcase
   end

   assign bus.o_lcd_rs   = rs_q;
   assign bus.o_lcd_rw   = 1'b0;
   assign bus.o_lcd_e    = e_q;
   assign bus.o_lcd_data = data_q;
   assign bus.o_ready    = ready_q;
   assign bus.o_busy     = !((state_q == ST_IDLE) && fifo_empty);
   assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer
// Directed bench for lcd_byte_writer at 1 MHz: POWERUP=100, EXEC=5, CLEAR=20,
// SETUP=1, E_HIGH=2, HOLD=1 cycles, FIFO depth 4. A monitor records every E
// pulse (rs, data, rise/fall cycle) and the main sequence checks the log.
module tb_lcd_byte_writer;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         riseCyc;
      int         fallCyc;
      logic       readyAtRise;
   } pulse_t;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b0;
   int         cyc = 0;
   int         assertCount = 0;
   int         failCount = 0;
   int         relCyc = 0;
   int         idleCyc = 0;
   logic       ePrev = 1'b0;
   pulse_t     cur;
   pulse_t     pulses[$];
   logic [7:0] initExp [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   lcd_byte_writer_if bus();

   lcd_byte_writer #(
      .CLK_FREQ_HZ   (1_000_000),
      .POWERUP_US    (100),
      .EXEC_US       (5),
      .CLEAR_US      (20),
      .SETUP_CYCLES  (1),
      .E_HIGH_CYCLES (2),
      .HOLD_CYCLES   (1),
      .FIFO_DEPTH    (4)
   ) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .bus       (bus)
   );

   always #5 i_clk = ~i_clk;

   // Cycle counter advances on the active edge; everything else reads it at
   // the falling edge so there is no ordering race.
   always @(posedge i_clk) cyc++;

   // Pulse logger: one record per E pulse, captured on the falling clock edge.
   always @(negedge i_clk) begin
      if (bus.o_lcd_e && !ePrev) begin
         cur.rs          = bus.o_lcd_rs;
         cur.data        = bus.o_lcd_data;
         cur.riseCyc     = cyc;
         cur.readyAtRise = bus.o_ready;
      end
      if (!bus.o_lcd_e && ePrev) begin
         cur.fallCyc = cyc;
         pulses.push_back(cur);
      end
      ePrev = bus.o_lcd_e;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One SPI frame, 4 cycles: slave-select low for 2, then high with the byte.
   // Must be called at a falling clock edge.
   task automatic applyStimulus(input logic [7:0] b);
      bus.i_ss = 1'b0;
      repeat (2) @(negedge i_clk);
      bus.i_ss   = 1'b1;
      bus.i_data = b;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic waitPulses(input int n, input int budget, input string tag);
      int k = 0;
      while (pulses.size() < n && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      checkOutput(tag, pulses.size(), n);
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int k = 0;
      while (bus.o_busy !== 1'b0 && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      idleCyc = cyc;
      checkOutput(tag, bus.o_busy, 0);
   endtask

   // Power-up plus the five init commands, shared by the first boot and the
   // boot after the mid-pulse reset.
   task automatic checkInit(input string tag);
      checkOutput({tag, "_powerup_delay"}, (pulses[0].riseCyc - relCyc) >= 100, 1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("%s_rs%0d", tag, i), pulses[i].rs, 0);
         checkOutput($sformatf("%s_data%0d", tag, i), pulses[i].data, initExp[i]);
         checkOutput($sformatf("%s_width%0d", tag, i), pulses[i].fallCyc - pulses[i].riseCyc, 2);
      end
      checkOutput({tag, "_gap_after_38"}, (pulses[1].riseCyc - pulses[0].fallCyc) >= 5, 1);
      checkOutput({tag, "_gap_after_clear"}, (pulses[4].riseCyc - pulses[3].fallCyc) >= 20, 1);
      checkOutput({tag, "_ready_low_during_init"}, pulses[4].readyAtRise, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      bus.i_ss   = 1'b1;
      bus.i_data = 8'h00;

      // Reset values
      repeat (3) @(negedge i_clk);
      checkOutput("rst_e", bus.o_lcd_e, 0);
      checkOutput("rst_rs", bus.o_lcd_rs, 0);
      checkOutput("rst_rw", bus.o_lcd_rw, 0);
      checkOutput("rst_data", bus.o_lcd_data, 8'h00);
      checkOutput("rst_ready", bus.o_ready, 0);
      checkOutput("rst_busy", bus.o_busy, 1);
      checkOutput("rst_overflow", bus.o_overflow, 0);

      // Scenario 1: init sequence
      $display("[TB] init sequence");
      i_reset_n = 1'b1;
      relCyc = cyc;
      waitPulses(5, 400, "init_pulse_count");
      if (pulses.size() >= 5) begin
         checkInit("init");
      end
      k = 0;
      while (!bus.o_ready && k < 100) begin
         @(negedge i_clk);
         k++;
      end
      checkOutput("init_ready", bus.o_ready, 1);
      if (pulses.size() >= 5) begin
         checkOutput("init_ready_after_wait", (cyc - pulses[4].fallCyc) >= 5, 1);
      end

      // Scenario 2: plain data byte
      $display("[TB] data write");
      pulses.delete();
      applyStimulus(8'h41);
      waitPulses(1, 100, "data_pulse_count");
      waitIdle(100, "data_idle");
      if (pulses.size() >= 1) begin
         checkOutput("data_rs", pulses[0].rs, 1);
         checkOutput("data_byte", pulses[0].data, 8'h41);
         checkOutput("data_width", pulses[0].fallCyc - pulses[0].riseCyc, 2);
         checkOutput("data_exec_wait", (idleCyc - pulses[0].fallCyc) >= 5, 1);
      end
      checkOutput("data_hold_rs", bus.o_lcd_rs, 1);
      checkOutput("data_hold_byte", bus.o_lcd_data, 8'h41);

      // Scenario 3: escape to a clear command, then escaped 0xFE
      $display("[TB] escape");
      pulses.delete();
      applyStimulus(8'hFE);
      applyStimulus(8'h01);
      waitPulses(1, 100, "esc_clear_count");
      waitIdle(100, "esc_clear_idle");
      checkOutput("esc_clear_single", pulses.size(), 1);
      if (pulses.size() >= 1) begin
         checkOutput("esc_clear_rs", pulses[0].rs, 0);
         checkOutput("esc_clear_byte", pulses[0].data, 8'h01);
         checkOutput("esc_clear_wait", (idleCyc - pulses[0].fallCyc) >= 20, 1);
      end
      pulses.delete();
      applyStimulus(8'hFE);
      applyStimulus(8'hFE);
      waitPulses(1, 100, "esc_fe_count");
      waitIdle(100, "esc_fe_idle");
      checkOutput("esc_fe_single", pulses.size(), 1);
      if (pulses.size() >= 1) begin
         checkOutput("esc_fe_rs", pulses[0].rs, 0);
         checkOutput("esc_fe_byte", pulses[0].data, 8'hFE);
         checkOutput("esc_fe_short_wait", (idleCyc - pulses[0].fallCyc) < 20, 1);
      end

      // Scenario 4: overflow. A clear command is in flight for ~25 cycles
      // while five data frames arrive: four are queued, the fifth is dropped.
      $display("[TB] overflow");
      pulses.delete();
      checkOutput("ovf_clear_before", bus.o_overflow, 0);
      applyStimulus(8'hFE);
      applyStimulus(8'h01);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'h30 + 8'(i));
      end
      waitPulses(5, 300, "ovf_pulse_count");
      waitIdle(100, "ovf_idle");
      checkOutput("ovf_written", pulses.size(), 5);
      if (pulses.size() >= 5) begin
         checkOutput("ovf_cmd_rs", pulses[0].rs, 0);
         checkOutput("ovf_cmd_byte", pulses[0].data, 8'h01);
         for (int i = 1; i < 5; i++) begin
            checkOutput($sformatf("ovf_rs%0d", i), pulses[i].rs, 1);
            checkOutput($sformatf("ovf_byte%0d", i), pulses[i].data, 8'h30 + 8'(i - 1));
         end
      end
      checkOutput("ovf_flag", bus.o_overflow, 1);
      applyStimulus(8'h35);
      waitPulses(6, 100, "ovf_after_count");
      waitIdle(100, "ovf_after_idle");
      if (pulses.size() >= 6) begin
         checkOutput("ovf_after_byte", pulses[5].data, 8'h35);
      end
      checkOutput("ovf_sticky", bus.o_overflow, 1);

      // Scenario 6: reset while E is high, with one entry still queued
      $display("[TB] reset mid-pulse");
      pulses.delete();
      applyStimulus(8'h55);
      applyStimulus(8'h56);
      applyStimulus(8'h57);
      k = 0;
      while (!(bus.o_lcd_e === 1'b1 && bus.o_lcd_data === 8'h56) && k < 100) begin
         @(negedge i_clk);
         k++;
      end
      checkOutput("mid_e_seen", bus.o_lcd_e, 1);
      #2 i_reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_e", bus.o_lcd_e, 0);
      checkOutput("mid_rst_ready", bus.o_ready, 0);
      checkOutput("mid_rst_busy", bus.o_busy, 1);
      checkOutput("mid_rst_overflow", bus.o_overflow, 0);
      checkOutput("mid_rst_data", bus.o_lcd_data, 8'h00);
      repeat (3) @(negedge i_clk);
      pulses.delete();
      i_reset_n = 1'b1;
      relCyc = cyc;

      // Scenario 5: frames sent during power-up land after init, in order
      $display("[TB] frames during init");
      repeat (50) @(negedge i_clk);
      applyStimulus(8'h48);
      applyStimulus(8'h49);
      waitPulses(7, 500, "boot2_pulse_count");
      waitIdle(100, "boot2_idle");
      checkOutput("boot2_total", pulses.size(), 7);
      if (pulses.size() >= 7) begin
         checkInit("boot2");
         checkOutput("boot2_rs5", pulses[5].rs, 1);
         checkOutput("boot2_byte5", pulses[5].data, 8'h48);
         checkOutput("boot2_ready5", pulses[5].readyAtRise, 1);
         checkOutput("boot2_rs6", pulses[6].rs, 1);
         checkOutput("boot2_byte6", pulses[6].data, 8'h49);
      end
      checkOutput("boot2_ready", bus.o_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/lcd_byte_writer.md
Name: lcd_byte_writer

Overview:
- Consumes the 8-bit word latched by the SPI receive shift register on each rising edge of slave-select and drives an HD44780-compatible character LCD in 8-bit, write-only mode.
- Runs the LCD power-up/initialisation sequence, buffers received bytes in a small FIFO and generates RS/E/data timing.
- Observes the LCD execution delays so the ATmega128 can stream status text without handshaking.

Parameters:
- CLK_FREQ_HZ, 100_000_000, i_clk frequency; all microsecond delays are converted to cycles at elaboration.
- POWERUP_US, 40000, delay after reset release before the first init command.
- EXEC_US, 50, wait after a normal command or data write.
- CLEAR_US, 2000, wait after clear/home commands (0x01, 0x02, 0x03).
- SETUP_CYCLES, 4, RS/data-valid cycles before E rises.
- E_HIGH_CYCLES, 50, E pulse width in cycles.
- HOLD_CYCLES, 2, cycles RS/data are held after E falls.
- FIFO_DEPTH, 4, queued entries (power of 2).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ss  in  1  raw SPI slave-select from the MCU (asynchronous to i_clk).
- i_data  in  8  latched byte from the shift register; stable from the i_ss rising edge until the next one.
- o_lcd_rs  out  1  register select (0 = command, 1 = data).
- o_lcd_rw  out  1  tied 0 (write only).
- o_lcd_e  out  1  LCD enable strobe.
- o_lcd_data  out  8  LCD DB[7:0].
- o_ready  out  1  1 once the init sequence has completed.
- o_busy  out  1  1 unless in IDLE with the FIFO empty.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-low, also mid-operation):
  - Outputs: o_lcd_e=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_ready=0, o_busy=1, o_overflow=0.
  - FIFO emptied, escape flag cleared, state goes to POWERUP. Any in-flight E pulse is aborted.
- Frame capture:
  - i_ss passes through a 2-flop synchroniser. A 0->1 transition of the synchronised signal is a frame end; i_data is sampled in that same cycle.
  - Sampled byte 0xFE with the escape flag clear: set the escape flag, push nothing.
  - Otherwise push {rs, byte}, where rs=0 if the escape flag is set and rs=1 if it is not; then clear the escape flag. Consequence: 0xFE 0xFE issues command 0xFE, and data byte 0xFE is not expressible.
  - Capture is active in every state, including during init.
- FIFO:
  - 9 bits wide, FIFO_DEPTH entries.
  - Push while full: the byte is dropped, o_overflow is set and stays set until reset. The escape flag is still consumed.
  - A push and a pop in the same cycle are both honoured, including when full.
- FSM states:
  - POWERUP: count POWERUP_US, then go to INIT with idx=0.
  - INIT: issue init command idx (0x38, 0x38, 0x0C, 0x01, 0x06) with rs=0 through SETUP/E_HIGH/HOLD/WAIT. When idx=4 completes, set o_ready=1 and go to IDLE.
  - IDLE: if the FIFO is non-empty, pop and go to SETUP.
  - SETUP: drive rs/data for SETUP_CYCLES with E=0.
  - E_HIGH: E=1 for E_HIGH_CYCLES.
  - HOLD: E=0 with rs/data unchanged for HOLD_CYCLES.
  - WAIT: hold for CLEAR_US if rs=0 and data is in {0x01, 0x02, 0x03}, otherwise EXEC_US; then return to IDLE (or INIT when init is not yet finished).
- o_lcd_data and o_lcd_rs keep the last written value between transfers.
- The shared delay counter is sized by $clog2 of the largest cycle count. Maximum throughput is one entry per (SETUP+E_HIGH+HOLD+wait) cycles.

Decomposition:
- Shared package/include lcd_pkg:
  - state encodings;
  - escape byte constant (0xFE);
  - init command ROM (5 x 8 bits);
  - clear/home command codes;
  - US_TO_CYC conversion function.
- One sub-module, lcd_cmd_fifo: a synchronous 9-bit FIFO with full/empty flags and the same i_clk/i_reset_n.

Test Plan:
All scenarios use CLK_FREQ_HZ=1_000_000, POWERUP_US=100, EXEC_US=5, CLEAR_US=20, SETUP_CYCLES=1, E_HIGH_CYCLES=2, HOLD_CYCLES=1.
1. Init: release reset -> no E pulse for 100 cycles; then 5 E pulses with data 0x38, 0x38, 0x0C, 0x01, 0x06 and rs=0; the gap after 0x01 is ≥20 cycles; o_ready rises after the last wait.
2. Data write after ready: ss frame with i_data=0x41 -> one E pulse with rs=1, data=0x41, E high for exactly 2 cycles; o_busy returns to 0 after a 5-cycle wait.
3. Escape: frames 0xFE then 0x01 -> a single command pulse with rs=0, data=0x01, followed by a 20-cycle wait. Frames 0xFE, 0xFE -> command 0xFE.
4. Overflow: 6 data frames back to back while the first is executing -> 5 bytes are written in order (1 in flight + 4 queued), the 6th is dropped, o_overflow=1 and stays 1.
5. Frames during init: 0x48, 0x49 sent at cycle 50 -> written as data after 0x06 completes, in order.
6. Reset mid-pulse: assert i_reset_n=0 while E=1 -> o_lcd_e=0 immediately (asynchronous), o_ready=0, FIFO empty; after release, the full POWERUP delay repeats.
